counter_op_scheduler: RTL and testbench
=======================================

// Module: counter_op_scheduler
// PURPOSE
//  Shares the BCD counter datapath (ops: hold / +1 / +2 / -1) between two requesters.
//  Round-robin arbitration selects one request at a time.
//  Each accepted request is a burst of 1..2^REP_W-1 identical ops.
//  The block issues the burst to the counter one op per CLK, through a cnt_en/cnt_op strobe.
//  It sits between the switch/key front end and the counter register.
// PARAMETERS
//  REP_W   3   width of each burst-length field; max burst = 2**REP_W-1
// PORTS
//  CLK         in   1          system clock, rising edge
//  reset       in   1          asynchronous, active-high reset
//  req_valid   in   2          request pending, one bit per requester
//  req_op      in   4          {op1,op0}; 00 hold, 01 +1, 10 +2, 11 -1
//  req_rep     in   2*REP_W    {rep1,rep0}; burst length, 0 treated as 1
//  req_ready   out  2          one-cycle accept pulse to the granted requester
//  cnt_en      out  1          counter update strobe, one per op
//  cnt_op      out  2          op applied by the counter when cnt_en=1
//  grant_id    out  1          requester owning the current burst
//  busy        out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset values
//  - reset is asynchronous, active-high; clock is CLK.
//  - On reset: state=IDLE, req_ready=0, cnt_en=0, cnt_op=00, grant_id=0, busy=0.
//  - On reset: last_grant=1 and remaining=0.
//  Output timing
//  - All outputs are decoded from flops only; there is no combinational path from req_* to outputs.
//  State machine: IDLE -> ISSUE -> GAP -> IDLE
//  - IDLE, no req_valid bit set: stay in IDLE, outputs stay idle.
//  - IDLE, one req_valid bit set: grant that requester.
//  - IDLE, both bits set: grant the requester != last_grant.
//  - On grant:
//    - latch op and rep (rep=0 is loaded as 1) into remaining.
//    - set grant_id; last_grant <= grant_id.
//    - pulse req_ready[g]=1 for exactly one cycle, in the cycle after the grant decision.
//      The transfer occurs when req_valid & req_ready are both high.
//    - Go to ISSUE.
//  - ISSUE:
//    - cnt_en=1, cnt_op=latched op every cycle.
//    - remaining decrements by 1 each cycle; at remaining==1 go to GAP.
//  - GAP: cnt_en=0 for one cycle, guaranteeing a settle cycle for the display; then go to IDLE.
//  Latency (accept cycle = t)
//  - First cnt_en is at t+1; last cnt_en is at t+rep.
//  - GAP is at t+rep+1; the next accept is at t+rep+2 at the earliest.
//  Ordering and arithmetic
//  - Op 00 still produces rep strobes with cnt_op=00, so the counter holds for the full burst.
//  - Wrap-around (9+1->0, 8+2->0, 9+2->1, 0-1->9) belongs to the counter.
//    The scheduler never alters or merges ops.
//  Requester rules
//  - A requester holds req_valid, req_op and req_rep stable until its ready pulse.
//  - Deasserting valid before ready is a withdraw; it is legal and drops nothing.
//  - Inputs of the non-granted requester are ignored during ISSUE and GAP.
//  Reset mid-burst
//  - Reset mid-burst aborts it: cnt_en drops asynchronously and the remaining ops are discarded.
//  - No req_ready is issued for the aborted burst; it was already accepted.
//  Concurrency
//  - New valids arriving during ISSUE or GAP wait; they are arbitrated in the next IDLE cycle.
// TESTING
//  1. Reset then req_valid=01, op0=01, rep0=3 -> req_ready=01 once.
//     Then cnt_en high 3 cycles with cnt_op=01, 1 GAP cycle, then busy=0.
//  2. Both valid, ops +1/-1, rep=1 each, from reset -> grant 0 first, then grant 1.
//     cnt_op sequence 01, 11; the two strobes are separated by GAP and IDLE.
//  3. Both valid continuously for 4 bursts -> grant_id alternates 0,1,0,1; no starvation.
//  4. rep0=0, op0=10 -> exactly one cnt_en strobe with cnt_op=10.
//  5. rep0=7 -> 7 strobes.
//  6. Assert reset during the 2nd cycle of a rep=5 burst -> cnt_en=0 immediately.
//     After release: IDLE, busy=0, no further strobes until a new request.
//  7. req_valid pulsed for 1 cycle while busy, then dropped -> never granted, no req_ready.

Source files
------------

// File: rtl/counter_op_scheduler.sv
// Round-robin scheduler that shares the BCD counter datapath between two requesters.
// Each grant becomes a burst of identical ops issued one per clock on cnt_en/cnt_op.
module counter_op_scheduler #(
  parameter int REP_W = 3
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  input  logic [3:0]         req_op,
  input  logic [2*REP_W-1:0] req_rep,
  output logic [1:0]         req_ready,
  output logic               cnt_en,
  output logic [1:0]         cnt_op,
  output logic               grant_id,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t           state_q, state_d;
  logic [REP_W-1:0] remaining_q, remaining_d;
  logic [1:0]       op_q, op_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
  logic [1:0]       req_ready_q, req_ready_d;
  logic             cnt_en_q, cnt_en_d;
  logic [1:0]       cnt_op_q, cnt_op_d;
  logic             busy_q, busy_d;
  logic             gnt;
  logic [REP_W-1:0] rep_sel;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    op_d         = op_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    req_ready_d  = 2'b00;
    cnt_en_d     = 1'b0;
    cnt_op_d     = 2'b00;
    // Both pending: the requester not served last time wins.
    gnt          = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    rep_sel      = gnt ? req_rep[2*REP_W-1:REP_W] : req_rep[REP_W-1:0];

    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          op_d         = gnt ? req_op[3:2] : req_op[1:0];
          remaining_d  = (rep_sel == '0) ? REP_W'(1) : rep_sel;
          grant_id_d   = gnt;
          last_grant_d = gnt;
          req_ready_d  = gnt ? 2'b10 : 2'b01;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // A requester that dropped valid before its ready pulse completed has withdrawn.
        if ((req_ready_q != 2'b00) && !req_valid[grant_id_q]) begin
          state_d = IDLE;
        end else begin
          cnt_en_d    = 1'b1;
          cnt_op_d    = op_q;
          remaining_d = remaining_q - REP_W'(1);
          if (remaining_q == REP_W'(1)) begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      op_q         <= 2'b00;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      req_ready_q  <= 2'b00;
      cnt_en_q     <= 1'b0;
      cnt_op_q     <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      op_q         <= op_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      req_ready_q  <= req_ready_d;
      cnt_en_q     <= cnt_en_d;
      cnt_op_q     <= cnt_op_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign cnt_en    = cnt_en_q;
  assign cnt_op    = cnt_op_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_counter_op_scheduler.sv
// Directed bench for counter_op_scheduler: requester queues drive stimulus, a grant
// scoreboard predicts each ready pulse and the strobe train that must follow it.
module tb_counter_op_scheduler;

  logic       CLK;
  logic       reset;
  logic [1:0] req_valid;
  logic [3:0] req_op;
  logic [5:0] req_rep;
  logic [1:0] req_ready;
  logic       cnt_en;
  logic [1:0] cnt_op;
  logic       grant_id;
  logic       busy;

  counter_op_scheduler #(.REP_W(3)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_rep   (req_rep),
    .req_ready (req_ready),
    .cnt_en    (cnt_en),
    .cnt_op    (cnt_op),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] op;
    logic [2:0] rep;
  } req_t;

  typedef struct {
    logic       id;
    logic [1:0] op;
    int         n;
  } grant_t;

  req_t       pend0[$];
  req_t       pend1[$];
  grant_t     exp_q[$];
  int         errors;
  int         checks;
  int         due;
  logic       prev_en;
  logic       cur_id;
  logic [1:0] cur_op;
  logic [1:0] rdy_s;
  logic       en_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    req_valid = {pend1.size() > 0, pend0.size() > 0};
    if (pend0.size() > 0) begin
      req_op[1:0]  = pend0[0].op;
      req_rep[2:0] = pend0[0].rep;
    end
    if (pend1.size() > 0) begin
      req_op[3:2]  = pend1[0].op;
      req_rep[5:3] = pend1[0].rep;
    end
  endtask

  // Called at the falling edge: strobes must follow the last ready pulse exactly.
  task automatic monitor();
    grant_t e;
    int due_pre;
    due_pre = due;
    chk("cnt_en", cnt_en, due_pre > 0);
    if (due_pre > 0) begin
      if (cnt_en) begin
        chk("cnt_op", cnt_op, cur_op);
        chk("grant_id", grant_id, cur_id);
      end
      due--;
    end
    if (req_ready != 2'b00) begin
      chk("ready_expected", exp_q.size() > 0, 1);
      chk("ready_gap", (due_pre == 0) && !prev_en, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ready_id", req_ready, e.id ? 2'b10 : 2'b01);
        chk("busy_at_accept", busy, 1);
        cur_id = e.id;
        cur_op = e.op;
        due    = e.n;
      end
    end
    prev_en = cnt_en;
  endtask

  task automatic step();
    @(negedge CLK);
    monitor();
    rdy_s = req_ready;
    en_s  = cnt_en;
    @(posedge CLK);
    #1;
    if (rdy_s[0] && pend0.size() > 0) void'(pend0.pop_front());
    if (rdy_s[1] && pend1.size() > 0) void'(pend1.pop_front());
    drive();
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || exp_q.size() > 0 || due > 0 || busy) && k < 200) begin
      step();
      k++;
    end
    chk(tag, k < 200, 1);
    repeat (3) step();
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    reset = 1'b1;
    pend0.delete();
    pend1.delete();
    exp_q.delete();
    drive();
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_cnt_op", cnt_op, 2'b00);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge CLK);
    #2;
    reset   = 1'b0;
    due     = 0;
    prev_en = 1'b0;
  endtask

  task automatic wait_first_strobe(input string tag);
    int k;
    k = 0;
    en_s = 1'b0;
    while (!en_s && k < 30) begin
      step();
      k++;
    end
    chk(tag, en_s, 1);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    due       = 0;
    prev_en   = 1'b0;
    cur_id    = 1'b0;
    cur_op    = 2'b00;
    rdy_s     = 2'b00;
    en_s      = 1'b0;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_op    = 4'b0000;
    req_rep   = 6'b000000;
    do_reset();

    // Single +1 burst of 3
    pend0.push_back('{2'b01, 3'd3});
    exp_q.push_back('{1'b0, 2'b01, 3});
    drive();
    wait_idle("t1_done");

    // Both valid from reset: requester 0 first
    do_reset();
    pend0.push_back('{2'b01, 3'd1});
    pend1.push_back('{2'b11, 3'd1});
    exp_q.push_back('{1'b0, 2'b01, 1});
    exp_q.push_back('{1'b1, 2'b11, 1});
    drive();
    wait_idle("t2_done");

    // Continuous contention: strict alternation
    pend0.push_back('{2'b10, 3'd2});
    pend0.push_back('{2'b01, 3'd1});
    pend1.push_back('{2'b11, 3'd2});
    pend1.push_back('{2'b00, 3'd3});
    exp_q.push_back('{1'b0, 2'b10, 2});
    exp_q.push_back('{1'b1, 2'b11, 2});
    exp_q.push_back('{1'b0, 2'b01, 1});
    exp_q.push_back('{1'b1, 2'b00, 3});
    drive();
    wait_idle("t3_done");

    // rep=0 behaves as one op
    pend0.push_back('{2'b10, 3'd0});
    exp_q.push_back('{1'b0, 2'b10, 1});
    drive();
    wait_idle("t4_done");

    // Maximum burst
    pend0.push_back('{2'b01, 3'd7});
    exp_q.push_back('{1'b0, 2'b01, 7});
    drive();
    wait_idle("t5_done");

    // Reset in the second strobe cycle of a 5-op burst
    pend0.push_back('{2'b11, 3'd5});
    exp_q.push_back('{1'b0, 2'b11, 5});
    drive();
    wait_first_strobe("t6_first_strobe");
    #2;
    reset = 1'b1;
    #1;
    chk("t6_abort_cnt_en", cnt_en, 0);
    chk("t6_abort_busy", busy, 0);
    repeat (2) @(negedge CLK);
    #2;
    reset   = 1'b0;
    due     = 0;
    prev_en = 1'b0;
    repeat (10) step();
    chk("t6_idle_busy", busy, 0);
    chk("t6_queue_empty", exp_q.size(), 0);

    // One-cycle valid pulse from requester 1 while busy is never granted
    pend0.push_back('{2'b01, 3'd4});
    exp_q.push_back('{1'b0, 2'b01, 4});
    drive();
    wait_first_strobe("t7_first_strobe");
    req_valid[1] = 1'b1;
    req_op[3:2]  = 2'b01;
    req_rep[5:3] = 3'd1;
    step();
    chk("t7_pulse_dropped", req_valid[1], 0);
    wait_idle("t7_done");
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
